// File: rtl/enc_pkg.sv
// Shared types and helpers for the registered 8-to-3 encoder.
package enc_pkg;

    localparam int unsigned IN_W  = 8;
    localparam int unsigned OUT_W = 3;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OH_ZERO  = 2'd0,
        OH_ONE   = 2'd1,
        OH_MULTI = 2'd2
    } oh_class_t;

    // Classify a word as all-zero, exactly one-hot, or multi-hot.
    function automatic oh_class_t onehot_chk(input logic [IN_W-1:0] w);
        if (w == '0) begin
            return OH_ZERO;
        end
        if ((w & (w - IN_W'(1))) == '0) begin
            return OH_ONE;
        end
        return OH_MULTI;
    endfunction

endpackage

// File: rtl/prio_enc_8_3.sv
// Combinational 8-to-3 priority encoder; direction of priority is a parameter.
module prio_enc_8_3
    import enc_pkg::*;
#(
    parameter bit PRIORITY_HIGH = 1'b1
) (
    input  logic [IN_W-1:0]  in_word,
    output logic [OUT_W-1:0] idx,
    output logic             any
);

    // Later loop iterations overwrite earlier ones, so scan order sets the winner.
    always_comb begin
        idx = '0;
        for (int unsigned i = 0; i < IN_W; i++) begin
            if (PRIORITY_HIGH) begin
                if (in_word[i]) idx = OUT_W'(i);
            end else begin
                if (in_word[IN_W-1-i]) idx = OUT_W'(IN_W - 1 - i);
            end
        end
    end

    assign any = |in_word;

endmodule

// File: rtl/encode_8_3_reg.sv
// Registered 8-to-3 encoder with valid/ready handshake, multi-hot flag and
// saturating malformed-word counter.
module encode_8_3_reg
    import enc_pkg::*;
#(
    parameter bit          PRIORITY_HIGH = 1'b1,
    parameter int unsigned ERR_W         = 8
) (
    input  logic             clka,
    input  logic             rst,
    input  logic             E,
    input  logic [IN_W-1:0]  In,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] Out,
    output logic             V,
    output logic             err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ERR_W-1:0] err_cnt
);

    state_t           state;
    state_t           state_nxt;
    logic             load;
    logic             accept;
    logic             deliver;
    logic [OUT_W-1:0] prio_idx;
    logic             prio_any;
    logic [OUT_W-1:0] enc_idx;
    logic             enc_v;
    logic             enc_err;

    prio_enc_8_3 #(
        .PRIORITY_HIGH(PRIORITY_HIGH)
    ) u_prio (
        .in_word(In),
        .idx    (prio_idx),
        .any    (prio_any)
    );

    assign in_ready  = (state == EMPTY) || out_ready;
    assign out_valid = (state == FULL);
    assign accept    = in_valid && in_ready;
    assign deliver   = out_valid && out_ready;

    // A disabled encoder reports nothing, whatever the input word.
    always_comb begin
        enc_idx = '0;
        enc_v   = 1'b0;
        enc_err = 1'b0;
        if (E) begin
            enc_idx = prio_idx;
            enc_v   = prio_any;
            enc_err = (onehot_chk(In) == OH_MULTI);
        end
    end

    always_ff @(posedge clka) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        unique case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt = FULL;
                    load      = 1'b1;
                end
            end
            FULL: begin
                if (deliver) begin
                    if (accept) load      = 1'b1;
                    else        state_nxt = EMPTY;
                end
            end
        endcase
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            Out <= '0;
            V   <= 1'b0;
            err <= 1'b0;
        end else if (load) begin
            Out <= enc_idx;
            V   <= enc_v;
            err <= enc_err;
        end
    end

    // Saturating count: stops at all-ones, cleared only by reset.
    always_ff @(posedge clka) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (load && enc_err && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_encode_8_3_reg.sv
// Directed bench for encode_8_3_reg: decoder round-trip, priority, backpressure,
// counter saturation and reset behaviour across three parameterisations.
module tb_encode_8_3_reg;

    logic       clka;
    logic       rst;
    logic       E;
    logic [7:0] In;
    logic       in_valid;
    logic       out_ready;

    logic       in_ready0, in_ready1, in_ready2;
    logic [2:0] out0, out1, out2;
    logic       v0, v1, v2;
    logic       err0, err1, err2;
    logic       ov0, ov1, ov2;
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;

    int n_checks = 0;
    int n_err    = 0;

    initial clka = 1'b0;
    always #5 clka = ~clka;

    encode_8_3_reg #(.PRIORITY_HIGH(1'b1), .ERR_W(8)) dut_hi (
        .clka(clka), .rst(rst), .E(E), .In(In), .in_valid(in_valid),
        .in_ready(in_ready0), .Out(out0), .V(v0), .err(err0),
        .out_valid(ov0), .out_ready(out_ready), .err_cnt(cnt0)
    );

    encode_8_3_reg #(.PRIORITY_HIGH(1'b0), .ERR_W(8)) dut_lo (
        .clka(clka), .rst(rst), .E(E), .In(In), .in_valid(in_valid),
        .in_ready(in_ready1), .Out(out1), .V(v1), .err(err1),
        .out_valid(ov1), .out_ready(out_ready), .err_cnt(cnt1)
    );

    encode_8_3_reg #(.PRIORITY_HIGH(1'b1), .ERR_W(2)) dut_sat (
        .clka(clka), .rst(rst), .E(E), .In(In), .in_valid(in_valid),
        .in_ready(in_ready2), .Out(out2), .V(v2), .err(err2),
        .out_valid(ov2), .out_ready(out_ready), .err_cnt(cnt2)
    );

    // Reference 3-to-8 decoder: drives zero when disabled.
    function automatic logic [7:0] dec(input logic [2:0] a, input logic e);
        logic [7:0] one;
        one = 8'h01;
        return e ? (one << a) : 8'h00;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    // Offer one word with the consumer ready, then withdraw the offer.
    task automatic send(input logic e, input logic [7:0] w);
        in_valid  = 1'b1;
        E         = e;
        In        = w;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; E = 1'b0; In = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        check("rst_out_valid", 32'(ov0), 32'd0);
        check("rst_out", 32'(out0), 32'd0);
        check("rst_v_err", 32'({v0, err0}), 32'd0);
        check("rst_cnt", 32'(cnt0), 32'd0);
        check("rst_in_ready", 32'(in_ready0), 32'd1);

        // Round trip through the decoder, one result per cycle.
        rst = 1'b0; E = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            In = dec(3'(k), 1'b1);
            tick();
            check("rt_valid", 32'(ov0), 32'd1);
            check("rt_out", 32'(out0), 32'(k));
            check("rt_v_err", 32'({v0, err0}), 32'b10);
            check("rt_out_lo", 32'(out1), 32'(k));
        end
        check("rt_cnt", 32'(cnt0), 32'd0);
        in_valid = 1'b0;
        tick();
        check("rt_drain", 32'(ov0), 32'd0);

        // Disabled encoder, then all-zero word.
        send(1'b0, 8'h10);
        check("dis_out", 32'({out0, v0, err0}), 32'd0);
        check("dis_valid", 32'(ov0), 32'd1);
        send(1'b1, 8'h00);
        check("zero_out", 32'({out0, v0, err0}), 32'd0);
        check("zero_cnt", 32'(cnt0), 32'd0);

        // Multi-hot with both priority directions.
        send(1'b1, 8'b0010_0100);
        check("mh_hi_out", 32'(out0), 32'd5);
        check("mh_hi_v_err", 32'({v0, err0}), 32'b11);
        check("mh_hi_cnt", 32'(cnt0), 32'd1);
        check("mh_lo_out", 32'(out1), 32'd2);
        check("mh_lo_v_err", 32'({v1, err1}), 32'b11);
        check("mh_lo_cnt", 32'(cnt1), 32'd1);

        // Backpressure: hold 3 while 7 waits at the input.
        in_valid = 1'b1; E = 1'b1; In = 8'h08; out_ready = 1'b1;
        tick();
        In = 8'h80; out_ready = 1'b0;
        #1;
        check("bp_in_ready", 32'(in_ready0), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_hold_out", 32'(out0), 32'd3);
            check("bp_hold_valid", 32'(ov0), 32'd1);
            check("bp_hold_rdy", 32'(in_ready0), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_rdy", 32'(in_ready0), 32'd1);
        check("bp_deliver3", 32'(out0), 32'd3);
        tick();
        in_valid = 1'b0;
        check("bp_next7", 32'(out0), 32'd7);
        check("bp_next7_valid", 32'(ov0), 32'd1);
        tick();
        check("bp_no_dup", 32'(ov0), 32'd0);

        // Counter saturation on the narrow counter.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("sat_rst_cnt", 32'(cnt2), 32'd0);
        for (int k = 0; k < 5; k++) begin
            send(1'b1, 8'hFF);
            check("sat_cnt", 32'(cnt2), 32'((k < 3) ? k + 1 : 3));
            check("sat_wide_cnt", 32'(cnt0), 32'(k + 1));
            check("sat_out", 32'({out0, err0}), 32'({3'd7, 1'b1}));
            check("sat_out_lo", 32'(out1), 32'd0);
        end

        // Reset while holding a result and while a new word is offered.
        in_valid = 1'b1; E = 1'b1; In = 8'h04; out_ready = 1'b1;
        tick();
        out_ready = 1'b0; In = 8'h02;
        tick();
        check("mr_held", 32'({ov0, out0}), 32'({1'b1, 3'd2}));
        rst = 1'b1;
        tick();
        check("mr_valid", 32'(ov0), 32'd0);
        check("mr_out", 32'({out0, v0, err0}), 32'd0);
        check("mr_cnt", 32'(cnt0), 32'd0);
        check("mr_cnt_sat", 32'(cnt2), 32'd0);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("mr_dropped", 32'(ov0), 32'd0);

        // Undriven input while idle must not disturb anything.
        In = 8'bx; E = 1'bx;
        tick();
        tick();
        check("x_idle_valid", 32'(ov0), 32'd0);
        check("x_idle_out", 32'({out0, v0, err0}), 32'd0);
        check("x_idle_cnt", 32'(cnt0), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
